mul_seq_ctrl: RTL and testbench

Multi-cycle unsigned 32×32 multiply sequencer. It drives a single 32-bit adder with carry-out as a shift-and-add engine and produces either the low or the high 32 bits of the 64-bit product. It sits beside the ALU and serves RV32M MUL/MULHU. The core stalls on `busy` while a multiply is in flight. Requests and results use valid/ready handshakes.

---
 rtl/mul_seq_pkg.sv | 16 +
 rtl/AluAdder.sv | 14 +
 rtl/mul_seq_ctrl.sv | 119 +++++++++++
 tb/tb_mul_seq_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/mul_seq_pkg.sv
// Shared types and constants for the shift-and-add multiply sequencer.
// The state enum, the default operand width and the hi_sel encodings live here.
package mul_seq_pkg;

    localparam int WIDTH_DEFAULT = 32;

    localparam logic SEL_LO = 1'b0;
    localparam logic SEL_HI = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/AluAdder.sv
// Plain unsigned adder with carry-out, shared with the ALU datapath.
// The multiply sequencer uses one instance as its per-iteration adder.
module AluAdder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o
);

    assign {carry_o, sum_o} = {1'b0, a_i} + {1'b0, b_i};

endmodule

// File: rtl/mul_seq_ctrl.sv
// Multi-cycle unsigned multiplier: one shift-and-add iteration per cycle.
// Delivers either half of the double-width product through a valid/ready handshake.
module mul_seq_ctrl
    import mul_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             hi_sel,
    input  logic             abort,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   phi_q, phi_d;
    logic [WIDTH-1:0]   plo_q, plo_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sel_q, sel_d;
    logic               busy_q;

    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   addSum;
    logic               addCarry;

    assign addend = plo_q[0] ? a_q : '0;

    AluAdder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a_i     (phi_q),
        .b_i     (addend),
        .sum_o   (addSum),
        .carry_o (addCarry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            phi_q   <= '0;
            plo_q   <= '0;
            cnt_q   <= '0;
            sel_q   <= SEL_LO;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            phi_q   <= phi_d;
            plo_q   <= plo_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        phi_d   = phi_q;
        plo_d   = plo_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;

        unique case (state_q)
            IDLE: begin
                if (start_valid && !abort) begin
                    sel_d = hi_sel;
                    phi_d = '0;
                    // A zero operand makes the product trivially zero, so skip the iterations.
                    if ((op_a == '0) || (op_b == '0)) begin
                        plo_d   = '0;
                        state_d = DONE;
                    end else begin
                        a_d     = op_a;
                        plo_d   = op_b;
                        cnt_d   = '0;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    // Carry-out becomes the new accumulator MSB, so no product bit is lost.
                    {phi_d, plo_d} = {addCarry, addSum, plo_q[WIDTH-1:1]};
                    cnt_d          = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (abort || res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign start_ready = (state_q == IDLE);
    assign res_valid   = (state_q == DONE);
    assign busy        = busy_q;
    assign result      = !res_valid ? '0 : ((sel_q == SEL_HI) ? phi_q : plo_q);

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for the multiply sequencer: latency, both product halves,
// zero shortcut, backpressure, abort and asynchronous reset.
module tb_mul_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start_valid;
    logic        start_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        hi_sel;
    logic        abort;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] result;
    logic        busy;

    int compareCount;
    int errorCount;
    logic sawValid;

    mul_seq_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .op_a        (op_a),
        .op_b        (op_b),
        .hi_sel      (hi_sel),
        .abort       (abort),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .result      (result),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        assert (observed === expected)
        else begin
            errorCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Presents one request on a falling edge; returns 1 ns after the accepting rising edge.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic sel);
        @(negedge clk);
        op_a        = a;
        op_b        = b;
        hi_sel      = sel;
        start_valid = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
    endtask

    task automatic waitEdges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic handOff(input string tag);
        @(negedge clk);
        res_ready = 1'b1;
        #1;
        checkOutput({tag, " ready low during hand-off"}, {31'd0, start_ready}, 32'd0);
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        checkOutput({tag, " idle after hand-off"}, {31'd0, start_ready}, 32'd1);
        checkOutput({tag, " valid drops"}, {31'd0, res_valid}, 32'd0);
        checkOutput({tag, " busy drops"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic runFull(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic sel, input logic [31:0] expected);
        applyStimulus(a, b, sel);
        checkOutput({tag, " busy after accept"}, {31'd0, busy}, 32'd1);
        checkOutput({tag, " not ready after accept"}, {31'd0, start_ready}, 32'd0);
        waitEdges(31);
        checkOutput({tag, " valid not early"}, {31'd0, res_valid}, 32'd0);
        waitEdges(1);
        checkOutput({tag, " valid at E+33"}, {31'd0, res_valid}, 32'd1);
        checkOutput({tag, " result"}, result, expected);
        handOff(tag);
    endtask

    initial begin
        compareCount = 0;
        errorCount   = 0;
        rst_n        = 1'b0;
        start_valid  = 1'b0;
        op_a         = '0;
        op_b         = '0;
        hi_sel       = 1'b0;
        abort        = 1'b0;
        res_ready    = 1'b0;

        #12;
        checkOutput("reset start_ready", {31'd0, start_ready}, 32'd1);
        checkOutput("reset res_valid", {31'd0, res_valid}, 32'd0);
        checkOutput("reset busy", {31'd0, busy}, 32'd0);
        checkOutput("reset result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] basic products");
        runFull("3x5 lo", 32'd3, 32'd5, 1'b0, 32'h0000000F);
        runFull("3x5 hi", 32'd3, 32'd5, 1'b1, 32'h00000000);
        runFull("ones hi", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFE);
        runFull("ones lo", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h00000001);
        runFull("mixed lo", 32'h12345678, 32'h9ABCDEF0, 1'b0, 32'h242D2080);
        runFull("mixed hi", 32'h12345678, 32'h9ABCDEF0, 1'b1, 32'h0B00EA4E);

        $display("[TB] zero shortcut");
        applyStimulus(32'h00001234, 32'd0, 1'b0);
        checkOutput("zero b valid at E+1", {31'd0, res_valid}, 32'd1);
        checkOutput("zero b result", result, 32'd0);
        handOff("zero b");
        applyStimulus(32'd0, 32'hDEADBEEF, 1'b1);
        checkOutput("zero a valid at E+1", {31'd0, res_valid}, 32'd1);
        checkOutput("zero a result", result, 32'd0);
        handOff("zero a");

        $display("[TB] backpressure");
        applyStimulus(32'h00010000, 32'h00010000, 1'b1);
        waitEdges(32);
        for (int i = 0; i < 10; i++) begin
            checkOutput("bp result held", result, 32'h00000001);
            checkOutput("bp valid held", {31'd0, res_valid}, 32'd1);
            checkOutput("bp start_ready low", {31'd0, start_ready}, 32'd0);
            waitEdges(1);
        end
        handOff("bp");

        $display("[TB] abort");
        @(negedge clk);
        start_valid = 1'b1;
        abort       = 1'b1;
        op_a        = 32'd9;
        op_b        = 32'd9;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        abort       = 1'b0;
        checkOutput("abort+start rejected ready", {31'd0, start_ready}, 32'd1);
        checkOutput("abort+start rejected busy", {31'd0, busy}, 32'd0);

        applyStimulus(32'h00ABCDEF, 32'h00FEDCBA, 1'b0);
        waitEdges(10);
        checkOutput("abort pre busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        checkOutput("abort idle", {31'd0, start_ready}, 32'd1);
        checkOutput("abort busy", {31'd0, busy}, 32'd0);
        sawValid = res_valid;
        for (int i = 0; i < 30; i++) begin
            waitEdges(1);
            sawValid = sawValid | res_valid;
        end
        checkOutput("abort no result", {31'd0, sawValid}, 32'd0);
        runFull("7x6 after abort", 32'd7, 32'd6, 1'b0, 32'h0000002A);

        $display("[TB] async reset");
        applyStimulus(32'd100, 32'd3, 1'b0);
        waitEdges(5);
        checkOutput("rst pre busy", {31'd0, busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst async start_ready", {31'd0, start_ready}, 32'd1);
        checkOutput("rst async res_valid", {31'd0, res_valid}, 32'd0);
        checkOutput("rst async busy", {31'd0, busy}, 32'd0);
        checkOutput("rst async result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        runFull("2x2 after reset", 32'd2, 32'd2, 1'b0, 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, errorCount);
        $finish;
    end

endmodule
